// File: rtl/wb_rr_arbiter_if.sv
// Purpose: wishbone bundle between N masters, the arbiter and one slave.
// Latency: none, this is wiring only.
// Backpressure: none of its own; the owner holds the slave until ACK, RTY or abort.
// Ports: master-side m_* request/response vectors (master i packed at [i*W +: W]),
//        slave-side s_* single wishbone port, m_dat_r broadcast read data.
// Modports: slave  = arbiter view (wishbone slave to the masters, drives s_*),
//           master = environment view (bus masters plus the downstream slave).
interface wb_rr_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256
);
  logic [N_MASTERS-1:0]          m_cyc;
  logic [N_MASTERS-1:0]          m_stb;
  logic [N_MASTERS-1:0]          m_we;
  logic [N_MASTERS*ADDR_W-1:0]   m_adr;
  logic [N_MASTERS*DATA_W-1:0]   m_dat_w;
  logic [N_MASTERS*DATA_W/8-1:0] m_sel;
  logic [N_MASTERS-1:0]          m_ack;
  logic [N_MASTERS-1:0]          m_rty;
  logic [DATA_W-1:0]             m_dat_r;

  logic                          s_cyc;
  logic                          s_stb;
  logic                          s_we;
  logic [ADDR_W-1:0]             s_adr;
  logic [DATA_W-1:0]             s_dat_w;
  logic [DATA_W/8-1:0]           s_sel;
  logic                          s_ack;
  logic                          s_rty;
  logic [DATA_W-1:0]             s_dat_r;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    output m_ack, m_rty, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_ack, s_rty, s_dat_r
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_ack, m_rty, m_dat_r,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_ack, s_rty, s_dat_r
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Purpose: N-master to 1-slave wishbone arbiter, round-robin (RR_MODE=1) or fixed priority.
// Latency: 1 cycle from request in IDLE to s_cyc; s_ack/s_rty -> m_ack/m_rty combinational.
// Backpressure: owner holds the slave until ACK/RTY/abort; one IDLE cycle between transfers.
// Ports: clk, rst (async, active-high), bus (wb_rr_arbiter_if.slave),
//        grant (owner index, valid while busy), busy (BUSY state).
module wb_rr_arbiter #(
  parameter int  N_MASTERS = 2,
  parameter int  ADDR_W    = 28,
  parameter int  DATA_W    = 256,
  parameter int  RR_MODE   = 1,
  localparam int GW        = $clog2(N_MASTERS),
  localparam int SW        = DATA_W / 8
) (
  input  logic           clk,
  input  logic           rst,
  wb_rr_arbiter_if.slave bus,
  output logic [GW-1:0]  grant,
  output logic           busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          rr_ptr, rr_ptr_nxt, grant_nxt, winner, base;
  logic [N_MASTERS-1:0]   req;
  logic [2*N_MASTERS-1:0] req_rot;
  logic [GW:0]            win_sum;
  logic                   win_found;

  logic                   own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0]      own_adr;
  logic [DATA_W-1:0]      own_dat;
  logic [SW-1:0]          own_sel;

  assign req  = bus.m_cyc & bus.m_stb;
  assign busy = (state == BUSY);

  // Winner search: rotate the request vector so the search origin sits at bit 0,
  // take the first set bit, then map the offset back to a master index mod N.
  always_comb begin
    base      = (RR_MODE != 0) ? rr_ptr : '0;
    req_rot   = {req, req} >> base;
    win_sum   = '0;
    win_found = 1'b0;
    for (int j = 0; j < N_MASTERS; j++) begin
      if (!win_found && req_rot[j]) begin
        win_sum   = {1'b0, base} + (GW+1)'(j);
        win_found = 1'b1;
      end
    end
    if (win_sum >= (GW+1)'(N_MASTERS)) win_sum = win_sum - (GW+1)'(N_MASTERS);
    winner = win_sum[GW-1:0];
  end

  // Current owner's request fields.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant == GW'(i)) begin
        own_cyc = bus.m_cyc[i];
        own_stb = bus.m_stb[i];
        own_we  = bus.m_we[i];
        own_adr = bus.m_adr[i*ADDR_W +: ADDR_W];
        own_dat = bus.m_dat_w[i*DATA_W +: DATA_W];
        own_sel = bus.m_sel[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BUSY;
          grant_nxt = winner;
        end
      end
      BUSY: begin
        if (bus.s_ack || bus.s_rty) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == GW'(N_MASTERS-1)) ? '0 : grant + GW'(1);
        end else if (!own_cyc) begin
          // Abort: pointer untouched so the aborting master keeps its turn.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave side: controls gated by BUSY, data paths are plain muxes.
  assign bus.s_cyc   = busy & own_cyc;
  assign bus.s_stb   = busy & own_stb;
  assign bus.s_we    = busy & own_we;
  assign bus.s_adr   = own_adr;
  assign bus.s_dat_w = own_dat;
  assign bus.s_sel   = own_sel;
  assign bus.m_dat_r = bus.s_dat_r;

  // Responses reach only the owner, and only while BUSY.
  always_comb begin
    bus.m_ack = '0;
    bus.m_rty = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      bus.m_ack[i] = busy && (grant == GW'(i)) && bus.s_ack;
      bus.m_rty[i] = busy && (grant == GW'(i)) && bus.s_rty;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: three instances (N=2 RR, N=3 RR, N=3 fixed priority),
// a per-instance slave model, and a response scoreboard fed by the stimulus.
module tb_wb_rr_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam logic [AW-1:0] RTY_ADR = 28'h0000BAD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]    ack;
    logic [2:0]    rty;
    logic [DW-1:0] dat;
  } exp_t;
  exp_t q2[$], q3[$], qf[$];

  wb_rr_arbiter_if #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) b2();
  wb_rr_arbiter_if #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) b3();
  wb_rr_arbiter_if #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) bf();

  logic [0:0] g2;
  logic [1:0] g3, gf;
  logic       busy2, busy3, busyf;

  wb_rr_arbiter #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .grant(g2), .busy(busy2));
  wb_rr_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .grant(g3), .busy(busy3));
  wb_rr_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dutf (
    .clk(clk), .rst(rst), .bus(bf.slave), .grant(gf), .busy(busyf));

  function automatic logic [DW-1:0] dat_of(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  assign b2.s_dat_r = dat_of(b2.s_adr);
  assign b3.s_dat_r = dat_of(b3.s_adr);
  assign bf.s_dat_r = dat_of(bf.s_adr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic resp_cmp(input string nm, input exp_t e, input logic [2:0] ack,
                          input logic [2:0] rty, input logic [DW-1:0] dat);
    chk({nm, "_ack"}, 64'(ack), 64'(e.ack));
    chk({nm, "_rty"}, 64'(rty), 64'(e.rty));
    if (e.ack != 3'b000) chk({nm, "_dat_r"}, 64'(dat), 64'(e.dat));
  endtask

  task automatic unexp(input string nm, input logic [2:0] ack, input logic [2:0] rty);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_resp: got ack=%b rty=%b, expected no response", nm, ack, rty);
  endtask

  // Scoreboard monitors: one pop per cycle in which a response is presented.
  always @(negedge clk) begin
    if (|b2.m_ack || |b2.m_rty) begin
      if (q2.size() == 0) unexp("dut2", {1'b0, b2.m_ack}, {1'b0, b2.m_rty});
      else resp_cmp("dut2", q2.pop_front(), {1'b0, b2.m_ack}, {1'b0, b2.m_rty}, b2.m_dat_r);
    end
    if (|b3.m_ack || |b3.m_rty) begin
      if (q3.size() == 0) unexp("dut3", b3.m_ack, b3.m_rty);
      else resp_cmp("dut3", q3.pop_front(), b3.m_ack, b3.m_rty, b3.m_dat_r);
    end
    if (|bf.m_ack || |bf.m_rty) begin
      if (qf.size() == 0) unexp("dutf", bf.m_ack, bf.m_rty);
      else resp_cmp("dutf", qf.pop_front(), bf.m_ack, bf.m_rty, bf.m_dat_r);
    end
  end

  // Slave models: respond lat cycles after strobe, RTY for RTY_ADR, one-cycle pulses.
  int lat2 = 3, lat3 = 2, latf = 2;
  int cnt2 = 0, cnt3 = 0, cntf = 0;

  always begin
    @(posedge clk); #1;
    if (b2.s_ack || b2.s_rty) begin b2.s_ack = 1'b0; b2.s_rty = 1'b0; cnt2 = 0; end
    else if (b2.s_cyc && b2.s_stb) begin
      cnt2++;
      if (cnt2 >= lat2) begin
        if (b2.s_adr == RTY_ADR) b2.s_rty = 1'b1; else b2.s_ack = 1'b1;
      end
    end else cnt2 = 0;
  end

  always begin
    @(posedge clk); #1;
    if (b3.s_ack || b3.s_rty) begin b3.s_ack = 1'b0; b3.s_rty = 1'b0; cnt3 = 0; end
    else if (b3.s_cyc && b3.s_stb) begin
      cnt3++;
      if (cnt3 >= lat3) begin
        if (b3.s_adr == RTY_ADR) b3.s_rty = 1'b1; else b3.s_ack = 1'b1;
      end
    end else cnt3 = 0;
  end

  always begin
    @(posedge clk); #1;
    if (bf.s_ack || bf.s_rty) begin bf.s_ack = 1'b0; bf.s_rty = 1'b0; cntf = 0; end
    else if (bf.s_cyc && bf.s_stb) begin
      cntf++;
      if (cntf >= latf) begin
        if (bf.s_adr == RTY_ADR) bf.s_rty = 1'b1; else bf.s_ack = 1'b1;
      end
    end else cntf = 0;
  end

  task automatic req2(input int i, input logic on, input logic [AW-1:0] a);
    b2.m_cyc[i] = on; b2.m_stb[i] = on; b2.m_we[i] = 1'b0;
    b2.m_adr[i*AW +: AW] = a; b2.m_dat_w[i*DW +: DW] = {a[15:0], 16'h0}; b2.m_sel[i*4 +: 4] = 4'hF;
  endtask

  task automatic req3(input int i, input logic on, input logic [AW-1:0] a);
    b3.m_cyc[i] = on; b3.m_stb[i] = on; b3.m_we[i] = 1'b0;
    b3.m_adr[i*AW +: AW] = a; b3.m_dat_w[i*DW +: DW] = {a[15:0], 16'h0}; b3.m_sel[i*4 +: 4] = 4'hF;
  endtask

  task automatic reqf(input int i, input logic on, input logic [AW-1:0] a);
    bf.m_cyc[i] = on; bf.m_stb[i] = on; bf.m_we[i] = 1'b0;
    bf.m_adr[i*AW +: AW] = a; bf.m_dat_w[i*DW +: DW] = {a[15:0], 16'h0}; bf.m_sel[i*4 +: 4] = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b2.m_cyc = '0; b2.m_stb = '0; b2.m_we = '0; b2.m_adr = '0; b2.m_dat_w = '0; b2.m_sel = '0;
    b3.m_cyc = '0; b3.m_stb = '0; b3.m_we = '0; b3.m_adr = '0; b3.m_dat_w = '0; b3.m_sel = '0;
    bf.m_cyc = '0; bf.m_stb = '0; bf.m_we = '0; bf.m_adr = '0; bf.m_dat_w = '0; bf.m_sel = '0;
    b2.s_ack = 1'b0; b2.s_rty = 1'b0;
    b3.s_ack = 1'b0; b3.s_rty = 1'b0;
    bf.s_ack = 1'b0; bf.s_rty = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy2", 64'(busy2), 0);
    chk("rst_grant2", 64'(g2), 0);
    chk("rst_rr_ptr2", 64'(dut2.rr_ptr), 0);
    chk("rst_s_ctrl2", 64'({b2.s_cyc, b2.s_stb, b2.s_we}), 0);
    chk("rst_m_resp2", 64'({b2.m_ack, b2.m_rty}), 0);
    chk("rst_busy3", 64'(busy3), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request: master 1 read at 0x0000123
    @(posedge clk); #1;
    req2(1, 1'b1, 28'h0000123);
    q2.push_back(exp_t'{3'b010, 3'b000, dat_of(28'h0000123)});
    @(negedge clk);
    chk("single_s_cyc_idle", 64'(b2.s_cyc), 0);
    @(negedge clk);
    chk("single_s_cyc", 64'(b2.s_cyc), 1);
    chk("single_s_adr", 64'(b2.s_adr), 64'h0000123);
    chk("single_s_dat_w", 64'(b2.s_dat_w), 64'h0123_0000);
    chk("single_s_sel", 64'(b2.s_sel), 64'hF);
    chk("single_grant", 64'(g2), 1);
    n = 0;
    while (b2.m_ack[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("single_ack_seen", 64'(b2.m_ack[1]), 1);
    @(posedge clk); #1 req2(1, 1'b0, '0);
    @(negedge clk);
    chk("single_rr_ptr", 64'(dut2.rr_ptr), 0);
    chk("single_busy_after", 64'(busy2), 0);

    // Abort on N=3: master 1 drops m_cyc before any response
    lat3 = 1000;
    @(posedge clk); #1 req3(1, 1'b1, 28'h0000045);
    repeat (2) @(negedge clk);
    chk("abort_busy", 64'(busy3), 1);
    chk("abort_grant", 64'(g3), 1);
    @(posedge clk); #1 req3(1, 1'b0, 28'h0000045);
    @(negedge clk);
    chk("abort_s_cyc_drop", 64'(b3.s_cyc), 0);
    @(negedge clk);
    chk("abort_idle", 64'(busy3), 0);
    chk("abort_rr_ptr", 64'(dut3.rr_ptr), 0);
    // Late s_ack while IDLE
    @(posedge clk); #2 b3.s_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_m_resp", 64'({b3.m_ack, b3.m_rty}), 0);
    chk("late_ack_busy", 64'(busy3), 0);
    @(negedge clk);
    chk("late_ack_state", 64'(busy3), 0);

    // Round-robin, all three masters requesting continuously for 6 transfers
    lat3 = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) req3(i, 1'b1, AW'(28'h100 + i));
    for (int k = 0; k < 6; k++)
      q3.push_back(exp_t'{3'(1 << (k % 3)), 3'b000, dat_of(AW'(28'h100 + k % 3))});
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (busy3 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("rr_grant", 64'(g3), 64'(k % 3));
      n = 0;
      while (b3.m_ack === 3'b000 && n < 20) begin @(negedge clk); n++; end
      chk("rr_ack_seen", 64'(|b3.m_ack), 1);
      if (k == 5) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) req3(i, 1'b0, '0);
      end else begin
        @(negedge clk);
        chk("rr_gap_idle", 64'(busy3), 0);
        @(negedge clk);
        chk("rr_gap_regrant", 64'(busy3), 1);
      end
    end

    // RTY and pointer wrap: master 1 ACK (ptr->2), master 2 RTY (ptr wraps to 0)
    @(negedge clk);
    @(posedge clk); #1;
    req3(1, 1'b1, 28'h0000201);
    req3(2, 1'b1, RTY_ADR);
    q3.push_back(exp_t'{3'b010, 3'b000, dat_of(28'h0000201)});
    q3.push_back(exp_t'{3'b000, 3'b100, 32'h0});
    @(negedge clk);
    n = 0;
    while (b3.m_ack[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rty_pre_ack", 64'(b3.m_ack[1]), 1);
    @(posedge clk); #1 req3(1, 1'b0, '0);
    @(negedge clk);
    chk("rty_pre_rr_ptr", 64'(dut3.rr_ptr), 2);
    n = 0;
    while (b3.m_rty[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rty_seen", 64'(b3.m_rty[2]), 1);
    chk("rty_grant", 64'(g3), 2);
    @(posedge clk); #1;
    req3(0, 1'b1, 28'h0000300);
    req3(2, 1'b1, 28'h0000302);
    q3.push_back(exp_t'{3'b001, 3'b000, dat_of(28'h0000300)});
    @(negedge clk);
    chk("rty_wrap_rr_ptr", 64'(dut3.rr_ptr), 0);
    chk("rty_exit_idle", 64'(busy3), 0);
    @(negedge clk);
    chk("rty_next_busy", 64'(busy3), 1);
    chk("rty_next_grant", 64'(g3), 0);
    n = 0;
    while (b3.m_ack[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rty_next_ack", 64'(b3.m_ack[0]), 1);
    @(posedge clk); #1;
    req3(0, 1'b0, '0);
    req3(2, 1'b0, '0);

    // Fixed priority: masters 0 and 2 requesting, master 0 always wins
    @(posedge clk); #1;
    reqf(0, 1'b1, 28'h0000400);
    reqf(2, 1'b1, 28'h0000402);
    repeat (3) qf.push_back(exp_t'{3'b001, 3'b000, dat_of(28'h0000400)});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n = 0;
      while (bf.m_ack[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("fp_ack0", 64'(bf.m_ack[0]), 1);
      chk("fp_grant0", 64'(gf), 0);
    end
    @(posedge clk); #1 reqf(0, 1'b0, '0);
    qf.push_back(exp_t'{3'b100, 3'b000, dat_of(28'h0000402)});
    @(negedge clk);
    n = 0;
    while (bf.m_ack[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("fp_ack2", 64'(bf.m_ack[2]), 1);
    chk("fp_grant2", 64'(gf), 2);
    @(posedge clk); #1 reqf(2, 1'b0, '0);

    // Reset in mid-transfer on N=2, master 1
    lat2 = 1000;
    @(posedge clk); #1 req2(1, 1'b1, 28'h0000055);
    repeat (2) @(negedge clk);
    chk("mid_rst_busy_before", 64'(busy2), 1);
    chk("mid_rst_s_cyc_before", 64'(b2.s_cyc), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s_cyc", 64'(b2.s_cyc), 0);
    chk("mid_rst_s_stb", 64'(b2.s_stb), 0);
    chk("mid_rst_busy", 64'(busy2), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy2), 1);
    chk("post_rst_grant", 64'(g2), 1);
    chk("post_rst_s_cyc", 64'(b2.s_cyc), 1);
    @(posedge clk); #1 req2(1, 1'b0, '0);
    repeat (2) @(negedge clk);

    chk("q2_drained", 64'(q2.size()), 0);
    chk("q3_drained", 64'(q3.size()), 0);
    chk("qf_drained", 64'(qf.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
